// File: rtl/mont_encode_if.sv
// rtl/mont_encode_if.sv - Stream bundle for the Montgomery-domain encoder.
interface mont_encode_if #(
  parameter int DATA_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_r;
  logic              out_last;
  logic              err;

  modport master (
    output in_valid, in_a, out_ready,
    input  in_ready, out_valid, out_r, out_last, err
  );

  modport slave (
    input  in_valid, in_a, out_ready,
    output in_ready, out_valid, out_r, out_last, err
  );
endinterface

// File: rtl/mont_encode.sv
// rtl/mont_encode.sv - 3-stage a*R mod q encoder (R = 2^16, q = 3329) via a*R2 + Montgomery reduction.
// Optional: MONT_RANGE_CHECK_EN builds a sticky err flag for accepted in_a >= Q.
module mont_encode #(
  parameter int DATA_W = 12,
  parameter int Q      = 3329,
  parameter int R2     = 1353,
  parameter int QINV   = 3327,
  parameter int N      = 256
) (
  input logic         clk,
  input logic         rst,
  mont_encode_if.slave bus
);
  localparam int TW = 2 * DATA_W;
  localparam int CW = $clog2(N);

  logic              adv;
  logic              fire_out;
  logic              v1_q;
  logic [TW-1:0]     t1_q, t1_d;
  logic              v2_q;
  logic [TW-1:0]     t2_q;
  logic [15:0]       m2_q, m2_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_r_q, out_r_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [29:0]       sum;
  logic [13:0]       u;

  assign adv      = !out_valid_q || bus.out_ready;
  assign fire_out = out_valid_q && bus.out_ready;

  always_comb begin
    t1_d = TW'(bus.in_a) * TW'(R2);
    m2_d = t1_q[15:0] * 16'(QINV);
    // t < Q*2^16 keeps u below 2Q, so one conditional subtract suffices
    sum  = 30'(t2_q) + 30'(m2_q) * 30'(Q);
    u    = 14'(sum >> 16);
    out_r_d = (u >= 14'(Q)) ? DATA_W'(u - 14'(Q)) : DATA_W'(u);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fire_out) begin
      cnt_d = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      t1_q        <= '0;
      v2_q        <= 1'b0;
      t2_q        <= '0;
      m2_q        <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      cnt_q       <= '0;
    end else begin
      if (adv) begin
        v1_q        <= bus.in_valid;
        t1_q        <= t1_d;
        v2_q        <= v1_q;
        t2_q        <= t1_q;
        m2_q        <= m2_d;
        out_valid_q <= v2_q;
        if (v2_q) begin
          out_r_q <= out_r_d;
        end
      end
      cnt_q <= cnt_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_last  = out_valid_q && (cnt_q == CW'(N - 1));

`ifdef MONT_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.in_valid && adv && (bus.in_a >= DATA_W'(Q))) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_mont_encode.sv
// tb/tb_mont_encode.sv - Directed-vector bench for mont_encode.
module tb_mont_encode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mont_encode_if #(.DATA_W(12)) bus ();
  mont_encode dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int a;
    int exp_r;
  } vec_t;

  vec_t tab[11];
  int   n_vec = 0;
  int   n_fail = 0;
  int   exp_q[$];
  int   exp_cnt = 0;
  logic exp_err = 1'b0;
  logic prev_stall = 1'b0;
  int   prev_r = 0;
  int   prev_last = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model(input int a);
    return ((a % 3329) * 2285) % 3329;
  endfunction

  // Entered at posedge+1; checks mid-cycle, returns at the next posedge+1.
  task automatic step(input logic v, input int a, input logic ordy, input int exp_r, output logic acc);
    logic [11:0] a12;
    a12 = a[11:0];
    bus.in_valid  = v;
    bus.in_a      = a12;
    bus.out_ready = ordy;
    #1;
    if (prev_stall) begin
      check("stall_out_valid", int'(bus.out_valid), 1);
      check("stall_out_r", int'(bus.out_r), prev_r);
      check("stall_out_last", int'(bus.out_last), prev_last);
    end
    if (bus.out_valid && !bus.out_ready) check("in_ready_stall", int'(bus.in_ready), 0);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", int'(bus.out_r), -1);
      else check("out_r", int'(bus.out_r), exp_q.pop_front());
      check("out_last", int'(bus.out_last), int'(exp_cnt == 255));
      exp_cnt = (exp_cnt + 1) % 256;
    end
    acc = v && bus.in_ready;
    if (acc) begin
      exp_q.push_back(exp_r);
`ifdef MONT_RANGE_CHECK_EN
      if (a >= 3329) exp_err = 1'b1;
`endif
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_r     = int'(bus.out_r);
    prev_last  = int'(bus.out_last);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    int n = 0;
    while (exp_q.size() > 0 && n < 600) begin
      step(1'b0, 0, 1'b1, 0, acc);
      n++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_cnt    = 0;
    exp_err    = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic run_stream(input int len);
    logic acc;
    for (int i = 0; i < len; i++) begin
      step(1'b1, i, 1'b1, model(i), acc);
      if (!acc) check("stream_accept", 0, 1);
    end
    drain();
  endtask

  initial begin
    logic acc;
    int   lat;
    int   tries;
    int   a;

    tab[0]  = '{0, 0};
    tab[1]  = '{1, 2285};
    tab[2]  = '{2, 1241};
    tab[3]  = '{3328, 1044};
    tab[4]  = '{3, 197};
    tab[5]  = '{3329, 0};
    tab[6]  = '{1000, 1306};
    tab[7]  = '{4095, 2585};
    tab[8]  = '{3330, 2285};
    tab[9]  = '{3327, 2088};
    tab[10] = '{1664, 522};

    reset_dut();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_r", int'(bus.out_r), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);

    // Single-input latency
    bus.in_valid = 1'b1;
    bus.in_a     = 12'd1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 3);
    check("lat_out_r", int'(bus.out_r), 2285);
    @(posedge clk);
    #1;
    exp_cnt = 1;

    // Table vectors, back to back
    for (int i = 0; i < 11; i++) begin
      step(1'b1, tab[i].a, 1'b1, tab[i].exp_r, acc);
      if (!acc) check("tab_accept", 0, 1);
    end
    drain();
    check("err_after_table", int'(bus.err), int'(exp_err));

    // Two full polynomials: out_last on each 256th output
    reset_dut();
    run_stream(256);
    run_stream(256);
    check("err_after_streams", int'(bus.err), int'(exp_err));

    // Random back-pressure over 50 values
    for (int i = 0; i < 50; i++) begin
      a = (i * 67 + 5) % 3329;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 100) begin
        step(1'b1, a, 1'($urandom_range(0, 1)), model(a), acc);
        tries++;
      end
      if (!acc) check("bp_accept_timeout", 0, 1);
    end
    drain();

    // Mid-stream reset with counter at 100 and the pipe full under stall
    reset_dut();
    run_stream(100);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 500 + i, 1'b0, model(500 + i), acc);
    end
    tries = 0;
    while (!bus.out_valid && tries < 10) begin
      @(posedge clk);
      #1;
      tries++;
    end
    check("pre_rst_out_valid", int'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", int'(bus.out_valid), 0);
    check("async_rst_out_last", int'(bus.out_last), 0);
    check("async_rst_err", int'(bus.err), 0);
    check("async_rst_out_r", int'(bus.out_r), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    exp_q.delete();
    exp_cnt    = 0;
    exp_err    = 1'b0;
    prev_stall = 1'b0;
    run_stream(256);
    check("err_end", int'(bus.err), int'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/mont_encode.md
Name: mont_encode

Overview:
- Streaming converter from the normal domain into the Montgomery domain (R = 2^16) for ML-KEM coefficients, q = 3329.
- Computes out = a·R mod q as a·R2 (R2 = R^2 mod q) followed by a Montgomery reduction.
- Sits in front of the NTT/multiplier datapath; its results feed the Montgomery-domain core, and the existing Montgomery reducer later takes values back out.
- Fixed-latency 3-stage pipeline with valid/ready flow control and a per-polynomial last marker.

Parameters:
- DATA_W, 12, coefficient width.
- Q, 3329, modulus.
- R2, 1353, 2^32 mod Q.
- QINV, 3327, −Q^-1 mod 2^16.
- N, 256, coefficients per polynomial (out_last period).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_a is valid.
- in_ready  output  1  block accepts in_a this cycle.
- in_a  input  DATA_W  normal-domain coefficient.
- out_valid  output  1  out_r is valid.
- out_ready  input  1  downstream accepts out_r.
- out_r  output  DATA_W  Montgomery-domain coefficient, range [0, Q).
- out_last  output  1  marks the N-th output of each polynomial.
- err  output  1  sticky input-range error (see Optional Feature).

Behaviour:
- Reset (asynchronous, any time, including mid-stream):
  - All stage valid bits = 0; out_valid = 0, out_r = 0, out_last = 0, err = 0.
  - Output counter = 0. In-flight data is discarded.
- Advance enable: adv = !out_valid || out_ready. All three stages shift together when adv = 1 and hold when adv = 0.
- in_ready = adv, a combinational function of registered out_valid and out_ready. Transfer occurs when in_valid && in_ready.
- Stage 1 registers t = in_a·R2 (24 bits, unsigned) and v1 = in_valid && in_ready.
- Stage 2 registers t and m = (t[15:0]·QINV) mod 2^16, 16 bits; v2 = v1.
- Stage 3 computes u = (t + m·Q) >> 16 at ≥30-bit width; low 16 bits are always zero.
  - If u ≥ Q then u − Q, else u.
  - Registers the result into out_r; out_valid = v2.
- Latency: exactly 3 cycles from an accepted input to out_valid with no back-pressure. Throughput is 1 per cycle.
- Bubbles: stage valid bits propagate as 0. out_r holds its last value while out_valid = 0; it is don't-care for checking.
- Stall:
  - While out_valid && !out_ready, out_r, out_valid and out_last hold stable and all stages freeze.
  - No input is accepted and none is lost or duplicated.
- Output counter (0..N−1):
  - Increments on each out_valid && out_ready, wrapping N−1 → 0.
  - out_last = out_valid && (count == N−1).
- Arithmetic: correct for any in_a < 2^DATA_W, because t < Q·2^16; the result is always in [0, Q).
- Simultaneous pop on output and push on input in the same cycle is legal and required for full throughput.

Optional Feature:
- Macro MONT_RANGE_CHECK_EN.
- Defined:
  - An accepted in_a ≥ Q sets err (sticky until rst).
  - The value is still converted; the result equals (in_a mod Q)·R mod Q.
- Undefined: err is tied to 0 and no comparator is built. Conversion is identical.

Test Plan:
- Reset then single input in_a = 1, out_ready = 1 → out_valid rises exactly 3 cycles after acceptance with out_r = 2285. in_a = 0 → 0; in_a = 2 → 1241; in_a = 3328 → 1044.
- Back-to-back stream in_a = 0..255, out_ready = 1 → 256 consecutive outputs, each out_r = (a·2285) mod 3329, out_last high only on the 256th. A second stream of 256 → out_last high again on its 256th (wrap).
- out_ready toggled pseudo-randomly during a 50-value stream → in_ready low whenever out_valid && !out_ready. Output order and values match the model with no loss or duplication, and out_r is stable during stalls.
- Assert rst for 1 cycle with 2 values in flight and the counter at 100 → out_valid = 0 immediately, err = 0. Next stream's out_last lands on its 256th output.
- With MONT_RANGE_CHECK_EN: in_a = 3329 → out_r = 0, err = 1 and stays 1. in_a = 4095 → out_r = (766·2285) mod 3329. Without the macro: same out_r values, err stays 0.
